// File: rtl/micro_sequencer_if.sv
// Bundle between the micro-sequencer and its environment: next-state return path,
// flag/memory/programming inputs and the decoded current-microword fields.
interface micro_sequencer_if #(
  parameter int CTRL_W = 24,
  parameter int MW_W   = CTRL_W + 13
);
  logic [5:0]        next_addr;
  logic [3:0]        alu_flags;
  logic              mem_ready;
  logic              resume;
  logic              prog_we;
  logic [5:0]        prog_addr;
  logic [MW_W-1:0]   prog_data;
  logic [5:0]        upc;
  logic [1:0]        next_sel_type;
  logic [5:0]        direct_branch;
  logic [5:0]        seq_branch;
  logic [CTRL_W-1:0] ctrl;
  logic [3:0]        cond_flag;
  logic              stall;
  logic              halted;

  modport slave (
    input  next_addr, alu_flags, mem_ready, resume, prog_we, prog_addr, prog_data,
    output upc, next_sel_type, direct_branch, seq_branch, ctrl, cond_flag, stall, halted
  );

  modport master (
    output next_addr, alu_flags, mem_ready, resume, prog_we, prog_addr, prog_data,
    input  upc, next_sel_type, direct_branch, seq_branch, ctrl, cond_flag, stall, halted
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-program counter, 64-entry writable control store, condition flags and RUN/HALT control.
// Define MICRO_CALL_EN to add the one-entry call/return register.
module micro_sequencer #(
  parameter int CTRL_W     = 24,
  parameter int RESET_ADDR = 0,
  parameter int MW_W       = CTRL_W + 13
) (
  input logic             clk,
  input logic             reset,
  micro_sequencer_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state;
  logic [5:0]        upc_reg;
  logic [3:0]        cond_reg;
  logic              halted_reg;
  logic [MW_W-1:0]   store [64];

  logic              halt_bit;
  logic              flag_load;
  logic              wait_mem;
  logic [5:0]        seq_addr;
  logic              stall_now;

  // Microword layout MSB->LSB: halt, flag_load, wait_mem, call, ret, next_sel(2), direct(6), ctrl
  assign halt_bit  = store[upc_reg][MW_W-1];
  assign flag_load = store[upc_reg][MW_W-2];
  assign wait_mem  = store[upc_reg][MW_W-3];
  assign seq_addr  = upc_reg + 6'd1;
  assign stall_now = wait_mem & ~bus.mem_ready & (state == RUN);

  assign bus.upc           = upc_reg;
  assign bus.next_sel_type = store[upc_reg][CTRL_W+7:CTRL_W+6];
  assign bus.direct_branch = store[upc_reg][CTRL_W+5:CTRL_W];
  assign bus.seq_branch    = seq_addr;
  assign bus.ctrl          = store[upc_reg][CTRL_W-1:0];
  assign bus.cond_flag     = cond_reg;
  assign bus.stall         = stall_now;
  assign bus.halted        = halted_reg;

`ifdef MICRO_CALL_EN
  logic       call_bit;
  logic       ret_bit;
  logic [5:0] ret_addr;
  assign call_bit = store[upc_reg][MW_W-4];
  assign ret_bit  = store[upc_reg][MW_W-5];
`endif

  // Programming is only accepted while halted, so the running program never changes under itself.
  always_ff @(posedge clk) begin
    if (!reset && state == HALT && bus.prog_we) begin
      store[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      upc_reg    <= 6'(RESET_ADDR);
      cond_reg   <= 4'd0;
      halted_reg <= 1'b0;
`ifdef MICRO_CALL_EN
      ret_addr   <= 6'd0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (!stall_now) begin
            if (flag_load) begin
              cond_reg <= bus.alu_flags;
            end
            if (halt_bit) begin
              state      <= HALT;
              halted_reg <= 1'b1;
            end else begin
`ifdef MICRO_CALL_EN
              upc_reg <= ret_bit ? ret_addr : bus.next_addr;
              if (call_bit) begin
                ret_addr <= seq_addr;
              end
`else
              upc_reg <= bus.next_addr;
`endif
            end
          end
        end
        HALT: begin
          // The held word's halt bit is not looked at here, so resume always leaves HALT.
          if (bus.resume) begin
            upc_reg    <= bus.next_addr;
            state      <= RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the sequencer.
module tb_micro_sequencer;
  localparam int CTRL_W = 24;
  localparam int MW_W   = CTRL_W + 13;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   check_en = 0;
  bit   rand_mode = 0;

  micro_sequencer_if #(.CTRL_W(CTRL_W)) bus ();

  micro_sequencer #(.CTRL_W(CTRL_W), .RESET_ADDR(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  logic [MW_W-1:0] m_store [64];
  int              m_upc    = 0;
  logic [3:0]      m_cond   = 4'd0;
  bit              m_halted = 0;
  int              m_ret    = 0;

  function automatic logic [MW_W-1:0] mw(input bit h, input bit fl, input bit wm, input bit c,
                                          input bit r, input int sel, input int dir, input int ctl);
    logic [MW_W-1:0] w;
    w = {h, fl, wm, c, r, 2'(sel), 6'(dir), CTRL_W'(ctl)};
    return w;
  endfunction

  function automatic logic [MW_W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[MW_W-1:0];
  endfunction

  // Next-state unit stand-in: 0/1 sequential, 2 direct, 3 direct if cond_flag[0]
  function automatic logic [5:0] nsu();
    logic [MW_W-1:0] w;
    int sel, dir, seq;
    w   = m_store[m_upc];
    sel = int'(w[CTRL_W+7:CTRL_W+6]);
    dir = int'(w[CTRL_W+5:CTRL_W]);
    seq = (m_upc + 1) % 64;
    if (sel == 2 || (sel == 3 && m_cond[0])) return 6'(dir);
    return 6'(seq);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [MW_W-1:0] w;
    bit h, fl, wm, c, r;
    w  = m_store[m_upc];
    h  = w[MW_W-1];
    fl = w[MW_W-2];
    wm = w[MW_W-3];
    c  = w[MW_W-4];
    r  = w[MW_W-5];
    if (reset) begin
      m_upc = 0; m_cond = 4'd0; m_halted = 0; m_ret = 0;
    end else if (m_halted) begin
      if (bus.prog_we) m_store[bus.prog_addr] = bus.prog_data;
      if (bus.resume) begin
        m_upc = int'(bus.next_addr);
        m_halted = 0;
      end
    end else if (!(wm && !bus.mem_ready)) begin
      if (fl) m_cond = bus.alu_flags;
      if (h) m_halted = 1;
      else begin
        int nxt;
        nxt = int'(bus.next_addr);
`ifdef MICRO_CALL_EN
        if (r) nxt = m_ret;
        if (c) m_ret = (m_upc + 1) % 64;
`else
        if (c || r) nxt = int'(bus.next_addr);
`endif
        m_upc = nxt;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (check_en) begin
      logic [MW_W-1:0] w;
      w = m_store[m_upc];
      check("upc", 64'(bus.upc), 64'(m_upc));
      check("next_sel_type", 64'(bus.next_sel_type), 64'(w[CTRL_W+7:CTRL_W+6]));
      check("direct_branch", 64'(bus.direct_branch), 64'(w[CTRL_W+5:CTRL_W]));
      check("seq_branch", 64'(bus.seq_branch), 64'((m_upc + 1) % 64));
      check("ctrl", 64'(bus.ctrl), 64'(w[CTRL_W-1:0]));
      check("cond_flag", 64'(bus.cond_flag), 64'(m_cond));
      check("stall", 64'(bus.stall), 64'(!m_halted && w[MW_W-3] && !bus.mem_ready));
      check("halted", 64'(bus.halted), 64'(m_halted));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (rand_mode) begin
      reset         = ($urandom_range(199) == 0);
      bus.alu_flags = 4'($urandom);
      bus.mem_ready = 1'($urandom_range(1));
      bus.resume    = ($urandom_range(3) == 0);
      bus.prog_we   = 1'($urandom_range(1));
      bus.prog_addr = 6'($urandom);
      bus.prog_data = rand_word();
    end
    bus.next_addr = nsu();
    if (rand_mode && $urandom_range(3) == 0) bus.next_addr = 6'($urandom);
    #3;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_store[i] = rand_word();
    for (int i = 0; i < 3; i++) m_store[i] = mw(0, 0, 0, 0, 0, 1, 0, 'h100 + i);
    m_store[3]  = mw(0, 0, 0, 0, 0, 2, 63, 'h103);
    m_store[4]  = mw(0, 0, 0, 0, 0, 1, 0, 'h104);
    m_store[5]  = mw(0, 1, 1, 0, 0, 1, 0, 'h105);
    m_store[6]  = mw(0, 0, 0, 0, 0, 1, 0, 'h106);
    m_store[7]  = mw(1, 0, 0, 0, 0, 1, 0, 'h107);
    m_store[8]  = mw(0, 0, 0, 0, 0, 1, 0, 'h108);
    m_store[9]  = mw(0, 0, 0, 0, 0, 1, 0, 'h109);
    m_store[10] = mw(0, 0, 0, 1, 0, 2, 20, 'h10A);
    m_store[11] = mw(0, 0, 0, 0, 0, 1, 0, 'h10B);
    m_store[20] = mw(0, 0, 0, 0, 1, 1, 0, 'h114);
    m_store[21] = mw(0, 0, 0, 0, 0, 1, 0, 'h115);
    m_store[63] = mw(0, 0, 0, 0, 0, 1, 0, 'h13F);
    for (int i = 0; i < 64; i++) dut.store[i] = m_store[i];

    reset = 1'b1;
    bus.alu_flags = 4'd0; bus.mem_ready = 1'b0; bus.resume = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = 6'd0; bus.prog_data = '0;
    bus.next_addr = nsu();
    step();
    step();
    check_en = 1;
    check("reset upc", 64'(bus.upc), 64'd0);
    check("reset seq", 64'(bus.seq_branch), 64'd1);
    check("reset cond", 64'(bus.cond_flag), 64'd0);
    check("reset halted", 64'(bus.halted), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    reset = 1'b0;

    step(); check("seq upc1", 64'(bus.upc), 64'd1); check("seq br2", 64'(bus.seq_branch), 64'd2);
    check("ctrl w1", 64'(bus.ctrl), 64'h101);
    step(); check("seq upc2", 64'(bus.upc), 64'd2); check("seq br3", 64'(bus.seq_branch), 64'd3);
    step(); check("seq upc3", 64'(bus.upc), 64'd3);
    step(); check("wrap upc63", 64'(bus.upc), 64'd63); check("wrap seq0", 64'(bus.seq_branch), 64'd0);
    step(); check("wrap upc0", 64'(bus.upc), 64'd0);

    bus.next_addr = 6'd5; bus.alu_flags = 4'hA;
    step(); check("stall1 upc", 64'(bus.upc), 64'd5); check("stall1", 64'(bus.stall), 64'd1);
    step(); check("stall2", 64'(bus.stall), 64'd1); check("stall2 cond", 64'(bus.cond_flag), 64'd0);
    step(); check("stall3", 64'(bus.stall), 64'd1); check("stall3 upc", 64'(bus.upc), 64'd5);
    bus.mem_ready = 1'b1;
    #1 check("stall released", 64'(bus.stall), 64'd0);
    step(); check("after stall upc", 64'(bus.upc), 64'd6); check("after stall cond", 64'(bus.cond_flag), 64'hA);

    step(); check("upc7", 64'(bus.upc), 64'd7); check("not halted yet", 64'(bus.halted), 64'd0);
    step(); check("halted", 64'(bus.halted), 64'd1); check("halt hold upc", 64'(bus.upc), 64'd7);
    bus.prog_we = 1'b1; bus.prog_addr = 6'd8; bus.prog_data = mw(0, 0, 0, 0, 0, 1, 0, 'hABCDEF);
    step(); check("still halted", 64'(bus.halted), 64'd1); check("halt upc7", 64'(bus.upc), 64'd7);
    bus.prog_we = 1'b0; bus.resume = 1'b1;
    step(); check("resume upc8", 64'(bus.upc), 64'd8); check("resume halted", 64'(bus.halted), 64'd0);
    check("programmed ctrl", 64'(bus.ctrl), 64'hABCDEF);
    bus.resume = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = 6'd9; bus.prog_data = mw(0, 0, 0, 0, 0, 1, 0, 'h5A5A5A);
    step(); check("run write ignored", 64'(bus.ctrl), 64'h109);
    bus.prog_we = 1'b0;
    step(); check("call upc10", 64'(bus.upc), 64'd10);
    step(); check("call target", 64'(bus.upc), 64'd20);
    step();
`ifdef MICRO_CALL_EN
    check("return upc", 64'(bus.upc), 64'd11);
`else
    check("no-call upc", 64'(bus.upc), 64'd21);
`endif

    bus.next_addr = 6'd5; bus.mem_ready = 1'b0;
    step(); check("midstall upc", 64'(bus.upc), 64'd5); check("midstall stall", 64'(bus.stall), 64'd1);
    reset = 1'b1;
    step(); check("rst upc", 64'(bus.upc), 64'd0); check("rst stall", 64'(bus.stall), 64'd0);
    check("rst cond", 64'(bus.cond_flag), 64'd0); check("rst halted", 64'(bus.halted), 64'd0);
    reset = 1'b0;

    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
